// File: rtl/pfw_dispatch.sv
// Forwarding dispatcher: DMAC lookup on the head frame, rewrites the metadata
// destination/pkttype fields and forwards or drops the packet with 1-cycle latency.
module pfw_dispatch #(
    parameter int unsigned TBL_DEPTH = 8,
    parameter int unsigned PORT_NUM  = 8,
    parameter int unsigned CPU_PORT  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [133:0]        in_pfw_data,
    input  logic                in_pfw_data_wr,
    input  logic                in_pfw_valid,
    input  logic                in_pfw_valid_wr,
    input  logic [2:0]          in_pfw_pkttype,
    input  logic [101:0]        in_pfw_key,
    input  logic                cfg_tbl_wr,
    input  logic [3:0]          cfg_tbl_addr,
    input  logic                cfg_tbl_vld,
    input  logic [47:0]         cfg_tbl_dmac,
    input  logic [PORT_NUM-1:0] cfg_tbl_portmap,
    output logic [133:0]        out_pfw_data,
    output logic                out_pfw_data_wr,
    output logic                out_pfw_valid,
    output logic                out_pfw_valid_wr,
    output logic [63:0]         pfw_pktin_cnt,
    output logic [63:0]         pfw_drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

    state_t state_q, state_d;

    logic [TBL_DEPTH-1:0]                tbl_vld_q;
    logic [TBL_DEPTH-1:0][47:0]          tbl_dmac_q;
    logic [TBL_DEPTH-1:0][PORT_NUM-1:0]  tbl_map_q;

    logic [133:0] out_data_q, out_data_d;
    logic         out_wr_q, out_wr_d;
    logic         out_vld_q, out_vld_d;
    logic         out_vwr_q, out_vwr_d;
    logic [63:0]  pktin_q, pktin_d;
    logic [63:0]  drop_q, drop_d;

    logic                is_head, is_tail;
    logic [47:0]         key_dmac;
    logic [5:0]          key_inport;
    logic                hit;
    logic [PORT_NUM-1:0] hit_map;
    logic [PORT_NUM-1:0] dst;
    logic [PORT_NUM+7:0] dst_ext;
    logic [133:0]        head_frame;
    logic                fwd_now;
    logic                unused_smac;

    assign is_head     = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b01);
    assign is_tail     = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b10);
    assign key_dmac    = in_pfw_key[101:54];
    assign key_inport  = in_pfw_key[5:0];
    assign unused_smac = ^in_pfw_key[53:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld_q  <= '0;
            tbl_dmac_q <= '0;
            tbl_map_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                if (cfg_tbl_wr && (32'(cfg_tbl_addr) == i)) begin
                    tbl_vld_q[i]  <= cfg_tbl_vld;
                    tbl_dmac_q[i] <= cfg_tbl_dmac;
                    tbl_map_q[i]  <= cfg_tbl_portmap;
                end
            end
        end
    end

    // Lowest-index valid match wins
    always_comb begin
        hit     = 1'b0;
        hit_map = '0;
        for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
            if (!hit && tbl_vld_q[i] && (tbl_dmac_q[i] == key_dmac)) begin
                hit     = 1'b1;
                hit_map = tbl_map_q[i];
            end
        end
    end

    always_comb begin
        dst = '0;
        if (in_pfw_pkttype == 3'd2)
            dst = PORT_NUM'(1) << CPU_PORT;
        else if (hit)
            dst = hit_map;
        else if ((key_dmac == '1) || (in_pfw_pkttype == 3'd0) || (in_pfw_pkttype == 3'd1))
            dst = '1;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            if (32'(key_inport) == i)
                dst[i] = 1'b0;
        end
    end

    assign dst_ext = {8'h00, dst};

    always_comb begin
        head_frame          = in_pfw_data;
        head_frame[111:104] = dst_ext[7:0];
        head_frame[103:101] = in_pfw_pkttype;
    end

    // A head always restarts the packet; an unterminated forwarded packet counts as a drop
    always_comb begin
        state_d = state_q;
        fwd_now = 1'b0;
        if (is_head) begin
            fwd_now = (dst != '0);
            state_d = fwd_now ? S_FWD : S_DROP;
        end else if (state_q == S_FWD) begin
            fwd_now = 1'b1;
            if (is_tail)
                state_d = S_IDLE;
        end else if (state_q == S_DROP) begin
            if (is_tail)
                state_d = S_IDLE;
        end

        out_wr_d   = fwd_now && in_pfw_data_wr;
        out_data_d = out_wr_d ? (is_head ? head_frame : in_pfw_data) : '0;
        out_vwr_d  = fwd_now && in_pfw_valid_wr;
        out_vld_d  = out_vwr_d && in_pfw_valid;

        pktin_d = pktin_q + 64'(is_head);
        drop_d  = drop_q + 64'(is_head && (dst == '0)) + 64'(is_head && (state_q == S_FWD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_vwr_q  <= 1'b0;
            pktin_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
            out_vld_q  <= out_vld_d;
            out_vwr_q  <= out_vwr_d;
            pktin_q    <= pktin_d;
            drop_q     <= drop_d;
        end
    end

    assign out_pfw_data     = out_data_q;
    assign out_pfw_data_wr  = out_wr_q;
    assign out_pfw_valid    = out_vld_q;
    assign out_pfw_valid_wr = out_vwr_q;
    assign pfw_pktin_cnt    = pktin_q;
    assign pfw_drop_cnt     = drop_q;

endmodule

// File: tb/tb_pfw_dispatch.sv
// Directed bench for pfw_dispatch: hand-computed destinations, counters and
// frame images checked one cycle after each input frame.
module tb_pfw_dispatch;

    logic         clk;
    logic         rst_n;
    logic [133:0] in_pfw_data;
    logic         in_pfw_data_wr;
    logic         in_pfw_valid;
    logic         in_pfw_valid_wr;
    logic [2:0]   in_pfw_pkttype;
    logic [101:0] in_pfw_key;
    logic         cfg_tbl_wr;
    logic [3:0]   cfg_tbl_addr;
    logic         cfg_tbl_vld;
    logic [47:0]  cfg_tbl_dmac;
    logic [7:0]   cfg_tbl_portmap;
    logic [133:0] out_pfw_data;
    logic         out_pfw_data_wr;
    logic         out_pfw_valid;
    logic         out_pfw_valid_wr;
    logic [63:0]  pfw_pktin_cnt;
    logic [63:0]  pfw_drop_cnt;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned pkt_no;

    localparam logic [47:0] MAC_E0  = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_E1  = 48'h0200_0000_0001;
    localparam logic [47:0] MAC_E25 = 48'h0200_0000_0005;
    localparam logic [47:0] MAC_BC  = 48'hFFFF_FFFF_FFFF;

    pfw_dispatch #(.TBL_DEPTH(8), .PORT_NUM(8), .CPU_PORT(7)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_pfw_data      (in_pfw_data),
        .in_pfw_data_wr   (in_pfw_data_wr),
        .in_pfw_valid     (in_pfw_valid),
        .in_pfw_valid_wr  (in_pfw_valid_wr),
        .in_pfw_pkttype   (in_pfw_pkttype),
        .in_pfw_key       (in_pfw_key),
        .cfg_tbl_wr       (cfg_tbl_wr),
        .cfg_tbl_addr     (cfg_tbl_addr),
        .cfg_tbl_vld      (cfg_tbl_vld),
        .cfg_tbl_dmac     (cfg_tbl_dmac),
        .cfg_tbl_portmap  (cfg_tbl_portmap),
        .out_pfw_data     (out_pfw_data),
        .out_pfw_data_wr  (out_pfw_data_wr),
        .out_pfw_valid    (out_pfw_valid),
        .out_pfw_valid_wr (out_pfw_valid_wr),
        .pfw_pktin_cnt    (pfw_pktin_cnt),
        .pfw_drop_cnt     (pfw_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [3:0] addr, input logic vld, input logic [47:0] mac,
                       input logic [7:0] map);
        cfg_tbl_wr = 1'b1; cfg_tbl_addr = addr; cfg_tbl_vld = vld;
        cfg_tbl_dmac = mac; cfg_tbl_portmap = map;
        tick();
        cfg_tbl_wr = 1'b0;
    endtask

    // Sends nf frames; tail=0 leaves the packet unterminated, gap=1 idles once after the head
    task automatic send_pkt(input logic [47:0] mac, input logic [2:0] pt, input logic [5:0] inp,
                            input int unsigned nf, input bit tail, input bit gap,
                            input bit fwd, input logic [7:0] dst, input string tag);
        logic [1:0]   hdr;
        logic [133:0] f;
        logic [133:0] hf;
        bit           last;
        pkt_no++;
        in_pfw_key     = {mac, 48'h0A0B_0C0D_0E0F, inp};
        in_pfw_pkttype = pt;
        for (int unsigned i = 0; i < nf; i++) begin
            last = tail && (i == nf - 1);
            hdr  = (i == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            f    = {hdr, 4'h0, {4{mac[15:0], 8'(i), 8'(pkt_no)}}};
            in_pfw_data     = f;
            in_pfw_data_wr  = 1'b1;
            in_pfw_valid    = last;
            in_pfw_valid_wr = last;
            tick();
            cfg_tbl_wr = 1'b0;
            hf = f;
            hf[111:104] = dst;
            hf[103:101] = pt;
            if (fwd) begin
                check_eq({tag, "_data"}, out_pfw_data, (i == 0) ? hf : f);
                check_eq({tag, "_wr"}, 134'(out_pfw_data_wr), 134'(1));
                check_eq({tag, "_vwr"}, 134'(out_pfw_valid_wr), 134'(last));
                check_eq({tag, "_vld"}, 134'(out_pfw_valid), 134'(last));
            end else begin
                check_eq({tag, "_drop_data"}, out_pfw_data, '0);
                check_eq({tag, "_drop_wr"}, 134'(out_pfw_data_wr), 134'(0));
                check_eq({tag, "_drop_vwr"}, 134'(out_pfw_valid_wr), 134'(0));
            end
            if (gap && i == 0) begin
                in_pfw_data_wr = 1'b0;
                tick();
                check_eq({tag, "_gap_wr"}, 134'(out_pfw_data_wr), 134'(0));
            end
        end
        in_pfw_data     = '0;
        in_pfw_data_wr  = 1'b0;
        in_pfw_valid    = 1'b0;
        in_pfw_valid_wr = 1'b0;
    endtask

    task automatic check_cnt(input string tag, input logic [63:0] pktin, input logic [63:0] drop);
        check_eq({tag, "_pktin"}, 134'(pfw_pktin_cnt), 134'(pktin));
        check_eq({tag, "_drop"}, 134'(pfw_drop_cnt), 134'(drop));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; pkt_no = 0;
        rst_n = 1'b0;
        in_pfw_data = '0; in_pfw_data_wr = 1'b0; in_pfw_valid = 1'b0; in_pfw_valid_wr = 1'b0;
        in_pfw_pkttype = '0; in_pfw_key = '0;
        cfg_tbl_wr = 1'b0; cfg_tbl_addr = '0; cfg_tbl_vld = 1'b0; cfg_tbl_dmac = '0; cfg_tbl_portmap = '0;
        tick(); tick();
        check_eq("rst_data", out_pfw_data, '0);
        check_eq("rst_wr", 134'(out_pfw_data_wr), 134'(0));
        check_eq("rst_vwr", 134'(out_pfw_valid_wr), 134'(0));
        check_cnt("rst", 64'd0, 64'd0);
        rst_n = 1'b1;
        tick();

        cfg(4'd0, 1'b1, MAC_E0, 8'h06);
        send_pkt(MAC_E0, 3'd0, 6'd1, 4, 1, 0, 1, 8'h04, "hit_be");
        check_cnt("p1", 64'd1, 64'd0);

        send_pkt(48'hAABB_CCDD_EEFF, 3'd3, 6'd0, 3, 1, 0, 0, 8'h00, "tsn_miss");
        send_pkt(MAC_E0, 3'd0, 6'd1, 3, 1, 0, 1, 8'h04, "b2b");
        check_cnt("p3", 64'd3, 64'd1);

        cfg(4'd1, 1'b1, MAC_E1, 8'h01);
        send_pkt(MAC_E1, 3'd2, 6'd2, 3, 1, 0, 1, 8'h80, "ptp");
        send_pkt(MAC_BC, 3'd0, 6'd3, 3, 1, 0, 1, 8'hF7, "bcast");
        cfg(4'd2, 1'b1, MAC_E25, 8'h30);
        cfg(4'd5, 1'b1, MAC_E25, 8'h0C);
        send_pkt(MAC_E25, 3'd0, 6'd0, 3, 1, 0, 1, 8'h30, "prio");
        send_pkt(48'h0A00_0000_0001, 3'd1, 6'd7, 4, 1, 1, 1, 8'h7F, "rb_miss_gap");
        send_pkt(MAC_BC, 3'd3, 6'd0, 3, 1, 0, 1, 8'hFE, "tsn_bcast");
        send_pkt(MAC_E0, 3'd3, 6'd9, 3, 1, 0, 1, 8'h06, "inport_hi");
        cfg(4'd8, 1'b1, 48'h0C00_0000_0001, 8'hFF);
        send_pkt(48'h0C00_0000_0001, 3'd3, 6'd0, 3, 1, 0, 0, 8'h00, "addr_oob");
        check_cnt("p10", 64'd10, 64'd2);

        cfg_tbl_wr = 1'b1; cfg_tbl_addr = 4'd0; cfg_tbl_vld = 1'b1;
        cfg_tbl_dmac = MAC_E0; cfg_tbl_portmap = 8'h18;
        send_pkt(MAC_E0, 3'd0, 6'd1, 3, 1, 0, 1, 8'h04, "wr_same_cyc");
        send_pkt(MAC_E0, 3'd0, 6'd1, 3, 1, 0, 1, 8'h18, "wr_new");

        send_pkt(MAC_E0, 3'd0, 6'd1, 2, 0, 0, 1, 8'h18, "no_tail");
        send_pkt(MAC_E0, 3'd0, 6'd1, 3, 1, 0, 1, 8'h18, "after_no_tail");
        check_cnt("p14", 64'd14, 64'd3);
        send_pkt(MAC_E1, 3'd0, 6'd0, 3, 1, 0, 0, 8'h00, "self_only");
        check_cnt("p15", 64'd15, 64'd4);

        send_pkt(MAC_E0, 3'd0, 6'd1, 2, 0, 0, 1, 8'h18, "pre_rst");
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_data", out_pfw_data, '0);
        check_eq("midrst_wr", 134'(out_pfw_data_wr), 134'(0));
        check_cnt("midrst", 64'd0, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        in_pfw_data = {2'b11, 132'h5}; in_pfw_data_wr = 1'b1;
        tick();
        check_eq("orphan_body_wr", 134'(out_pfw_data_wr), 134'(0));
        in_pfw_data = {2'b10, 132'h6}; in_pfw_valid = 1'b1; in_pfw_valid_wr = 1'b1;
        tick();
        check_eq("orphan_tail_wr", 134'(out_pfw_data_wr), 134'(0));
        check_eq("orphan_tail_vwr", 134'(out_pfw_valid_wr), 134'(0));
        send_pkt(MAC_E0, 3'd0, 6'd1, 3, 1, 0, 1, 8'hFD, "post_rst");
        check_cnt("post_rst", 64'd1, 64'd0);
        tick();
        check_eq("idle_wr", 134'(out_pfw_data_wr), 134'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
